// File: rtl/adder_sched_pkg.sv
// -----------------------------------------------------------------------------
// adder_sched_pkg
// Shared constants and helpers for the round-robin scheduler that time-shares
// one 2-step pipelined adder (low half in step 1, high half + carry in step 2).
//   NUM_REQ  : number of requesters
//   DATA_W   : operand width (even), split at HALF_W
//   ID_W     : requester id width
//   PIPE_LAT : accept-to-response latency in cycles (depth of the tag pipe)
// -----------------------------------------------------------------------------
package adder_sched_pkg;

   localparam int NUM_REQ  = 4;
   localparam int DATA_W   = 8;
   localparam int HALF_W   = DATA_W / 2;
   localparam int ID_W     = $clog2(NUM_REQ);
   localparam int PIPE_LAT = 3;

   // One stage of the owner-tag pipe that travels alongside the adder.
   typedef struct packed {
      logic            vld;
      logic [ID_W-1:0] id;
   } tag_t;

   // Requester id to one-hot vector; ids outside 0..NUM_REQ-1 give all zeros.
   function automatic logic [NUM_REQ-1:0] id_to_onehot(input logic [ID_W-1:0] id);
      logic [NUM_REQ-1:0] oh;
      oh = {NUM_REQ{1'b0}};
      for (int i = 0; i < NUM_REQ; i++) begin
         oh[i] = (id == ID_W'(i));
      end
      return oh;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin arbiter: grants the first eligible requester at or
// after the pointer, searching cyclically.
//   eligible  in  NUM_REQ  requesters that may be granted this cycle
//   ptr       in  ID_W     round-robin start index
//   grant     out NUM_REQ  one-hot grant (0 when nothing is eligible)
//   grant_id  out ID_W     index of the granted requester (0 when none)
//   any_grant out 1        something was granted
// -----------------------------------------------------------------------------
module rr_arbiter
   import adder_sched_pkg::*;
(
   input  logic [NUM_REQ-1:0] eligible,
   input  logic [ID_W-1:0]    ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [ID_W-1:0]    grant_id,
   output logic               any_grant
);

   logic [2*NUM_REQ-1:0] dbl_s;
   logic [NUM_REQ-1:0]   rot_s;
   logic [ID_W:0]        idx_s;
   logic                 found_s;

   // Rotate the eligible mask so the pointer lands on bit 0, then take the
   // lowest set bit and map it back to an absolute index (mod NUM_REQ).
   always_comb begin
      dbl_s    = {eligible, eligible} >> ptr;
      rot_s    = dbl_s[NUM_REQ-1:0];
      found_s  = 1'b0;
      idx_s    = {(ID_W+1){1'b0}};
      grant_id = {ID_W{1'b0}};
      for (int j = 0; j < NUM_REQ; j++) begin
         if (!found_s && rot_s[j]) begin
            found_s = 1'b1;
            idx_s   = {1'b0, ptr} + (ID_W+1)'(j);
            if (idx_s >= (ID_W+1)'(NUM_REQ)) begin
               idx_s = idx_s - (ID_W+1)'(NUM_REQ);
            end else begin
               idx_s = idx_s;
            end
            grant_id = idx_s[ID_W-1:0];
         end else begin
            found_s = found_s;
         end
      end
      any_grant = found_s;
      if (found_s) begin
         grant = id_to_onehot(grant_id);
      end else begin
         grant = {NUM_REQ{1'b0}};
      end
   end

endmodule

// File: rtl/adder_pipe_sched.sv
// -----------------------------------------------------------------------------
// adder_pipe_sched
// Round-robin scheduler sharing one external 2-step pipelined adder among
// NUM_REQ requesters. One op may be accepted per cycle; the high halves of the
// operands are skewed by one cycle because the adder samples them one edge
// after the low halves. An owner tag rides a PIPE_LAT-deep pipe so each result
// is returned to the requester that issued it.
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   req_en            per-requester enable mask
//   req_valid         per-requester op pending
//   req_a, req_b      packed operands, slice i = [i*DATA_W +: DATA_W]
//   req_cin           per-requester carry-in
//   req_ready         one-hot grant; op accepted when valid & ready
//   add_a/add_b/cin   registered operands to the adder
//   add_sum/add_cout  adder result, valid two cycles after issue
//   rsp_valid         one-hot single-cycle pulse per completed op
//   rsp_id/sum/cout   registered owner id and result (hold between responses)
// -----------------------------------------------------------------------------
module adder_pipe_sched
   import adder_sched_pkg::*;
(
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_REQ-1:0]        req_en,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*DATA_W-1:0] req_a,
   input  logic [NUM_REQ*DATA_W-1:0] req_b,
   input  logic [NUM_REQ-1:0]        req_cin,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic [DATA_W-1:0]         add_a,
   output logic [DATA_W-1:0]         add_b,
   output logic                      add_cin,
   input  logic [DATA_W-1:0]         add_sum,
   input  logic                      add_cout,
   output logic [NUM_REQ-1:0]        rsp_valid,
   output logic [ID_W-1:0]           rsp_id,
   output logic [DATA_W-1:0]         rsp_sum,
   output logic                      rsp_cout
);

   logic [NUM_REQ-1:0] eligible_s;
   logic [NUM_REQ-1:0] grant_s;
   logic [ID_W-1:0]    grant_id_s;
   logic               any_grant_s;
   logic               accept_s;
   logic [DATA_W-1:0]  sel_a_s;
   logic [DATA_W-1:0]  sel_b_s;
   logic               sel_cin_s;

   logic [ID_W-1:0]    ptr_r;
   logic [DATA_W-1:0]  add_a_r;
   logic [DATA_W-1:0]  add_b_r;
   logic               add_cin_r;
   logic [HALF_W-1:0]  hi_a_r;
   logic [HALF_W-1:0]  hi_b_r;
   tag_t               tag_r [PIPE_LAT];
   logic [NUM_REQ-1:0] rsp_valid_r;
   logic [ID_W-1:0]    rsp_id_r;
   logic [DATA_W-1:0]  rsp_sum_r;
   logic               rsp_cout_r;

   assign eligible_s = req_valid & req_en;

   rr_arbiter u_arb (
      .eligible  (eligible_s),
      .ptr       (ptr_r),
      .grant     (grant_s),
      .grant_id  (grant_id_s),
      .any_grant (any_grant_s)
   );

   // The grant is masked while reset is held so no requester believes an op
   // was taken when the flops cannot capture it.
   assign req_ready = grant_s & {NUM_REQ{rst_n}};
   assign accept_s  = any_grant_s;

   // Select the granted requester's operands with a one-hot AND-OR mux.
   always_comb begin
      sel_a_s   = {DATA_W{1'b0}};
      sel_b_s   = {DATA_W{1'b0}};
      sel_cin_s = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         sel_a_s   = sel_a_s | (req_a[i*DATA_W +: DATA_W] & {DATA_W{grant_s[i]}});
         sel_b_s   = sel_b_s | (req_b[i*DATA_W +: DATA_W] & {DATA_W{grant_s[i]}});
         sel_cin_s = sel_cin_s | (req_cin[i] & grant_s[i]);
      end
   end

   // Round-robin pointer: moves just past the accepted requester, wrapping to 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_r <= {ID_W{1'b0}};
      end else if (accept_s) begin
         if (grant_id_s == ID_W'(NUM_REQ-1)) begin
            ptr_r <= {ID_W{1'b0}};
         end else begin
            ptr_r <= grant_id_s + ID_W'(1);
         end
      end else begin
         ptr_r <= ptr_r;
      end
   end

   // Issue registers: low halves and carry go out immediately; high halves wait
   // one cycle in the skew regs. The upper add_a/add_b fields load from the
   // skew regs on every edge, so a bubble only zeroes the new low fields and
   // never touches the high half of the op issued the cycle before.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         add_a_r   <= {DATA_W{1'b0}};
         add_b_r   <= {DATA_W{1'b0}};
         add_cin_r <= 1'b0;
         hi_a_r    <= {HALF_W{1'b0}};
         hi_b_r    <= {HALF_W{1'b0}};
      end else begin
         add_a_r[DATA_W-1:HALF_W] <= hi_a_r;
         add_b_r[DATA_W-1:HALF_W] <= hi_b_r;
         if (accept_s) begin
            add_a_r[HALF_W-1:0] <= sel_a_s[HALF_W-1:0];
            add_b_r[HALF_W-1:0] <= sel_b_s[HALF_W-1:0];
            add_cin_r           <= sel_cin_s;
            hi_a_r              <= sel_a_s[DATA_W-1:HALF_W];
            hi_b_r              <= sel_b_s[DATA_W-1:HALF_W];
         end else begin
            add_a_r[HALF_W-1:0] <= {HALF_W{1'b0}};
            add_b_r[HALF_W-1:0] <= {HALF_W{1'b0}};
            add_cin_r           <= 1'b0;
            hi_a_r              <= {HALF_W{1'b0}};
            hi_b_r              <= {HALF_W{1'b0}};
         end
      end
   end

   // Owner-tag pipe: stage 0 records the accept, later stages follow the adder.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < PIPE_LAT; k++) begin
            tag_r[k] <= '{vld: 1'b0, id: {ID_W{1'b0}}};
         end
      end else begin
         tag_r[0] <= '{vld: accept_s, id: grant_id_s};
         for (int k = 1; k < PIPE_LAT; k++) begin
            tag_r[k] <= tag_r[k-1];
         end
      end
   end

   // Response registers: capture the adder result when the tag in the last
   // stage is valid; data holds between responses, the valid pulse does not.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid_r <= {NUM_REQ{1'b0}};
         rsp_id_r    <= {ID_W{1'b0}};
         rsp_sum_r   <= {DATA_W{1'b0}};
         rsp_cout_r  <= 1'b0;
      end else if (tag_r[PIPE_LAT-1].vld) begin
         rsp_valid_r <= id_to_onehot(tag_r[PIPE_LAT-1].id);
         rsp_id_r    <= tag_r[PIPE_LAT-1].id;
         rsp_sum_r   <= add_sum;
         rsp_cout_r  <= add_cout;
      end else begin
         rsp_valid_r <= {NUM_REQ{1'b0}};
         rsp_id_r    <= rsp_id_r;
         rsp_sum_r   <= rsp_sum_r;
         rsp_cout_r  <= rsp_cout_r;
      end
   end

   assign add_a     = add_a_r;
   assign add_b     = add_b_r;
   assign add_cin   = add_cin_r;
   assign rsp_valid = rsp_valid_r;
   assign rsp_id    = rsp_id_r;
   assign rsp_sum   = rsp_sum_r;
   assign rsp_cout  = rsp_cout_r;

endmodule

// File: tb/tb_adder_pipe_sched.sv
// -----------------------------------------------------------------------------
// tb_adder_pipe_sched
// Bench for adder_pipe_sched. Contains a behavioural 2-step adder (low half on
// one edge, high half + carry on the next) feeding the DUT, a queue-based
// reference of expected responses (plain a+b+cin, due PIPE_LAT cycles after
// acceptance), a per-cycle compare process and directed literal checks.
// -----------------------------------------------------------------------------
module tb_adder_pipe_sched;
   import adder_sched_pkg::*;

   logic                      clk = 1'b0;
   logic                      rst_n = 1'b0;
   logic [NUM_REQ-1:0]        req_en = '0;
   logic [NUM_REQ-1:0]        req_valid = '0;
   logic [NUM_REQ*DATA_W-1:0] req_a = '0;
   logic [NUM_REQ*DATA_W-1:0] req_b = '0;
   logic [NUM_REQ-1:0]        req_cin = '0;
   logic [NUM_REQ-1:0]        req_ready;
   logic [DATA_W-1:0]         add_a, add_b, add_sum;
   logic                      add_cin, add_cout;
   logic [NUM_REQ-1:0]        rsp_valid;
   logic [ID_W-1:0]           rsp_id;
   logic [DATA_W-1:0]         rsp_sum;
   logic                      rsp_cout;

   int n_tests = 0;
   int n_fail  = 0;

   adder_pipe_sched dut (
      .clk(clk), .rst_n(rst_n), .req_en(req_en), .req_valid(req_valid),
      .req_a(req_a), .req_b(req_b), .req_cin(req_cin), .req_ready(req_ready),
      .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
      .add_sum(add_sum), .add_cout(add_cout),
      .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout)
   );

   always #5 clk = ~clk;

   // External 2-step adder: low half sampled first, high half one edge later.
   logic [HALF_W:0]   lo_q  = '0;
   logic [DATA_W:0]   sum_q = '0;
   always @(posedge clk) begin
      lo_q  <= {1'b0, add_a[HALF_W-1:0]} + {1'b0, add_b[HALF_W-1:0]} + {{HALF_W{1'b0}}, add_cin};
      sum_q <= {({1'b0, add_a[DATA_W-1:HALF_W]} + {1'b0, add_b[DATA_W-1:HALF_W]}
                 + {{HALF_W{1'b0}}, lo_q[HALF_W]}), lo_q[HALF_W-1:0]};
   end
   assign add_sum  = sum_q[DATA_W-1:0];
   assign add_cout = sum_q[DATA_W];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model state
   typedef struct { int due; int id; logic [DATA_W:0] res; } exp_t;
   typedef struct { int id; logic [DATA_W-1:0] sum; logic cout; } rsp_t;
   exp_t q[$];
   rsp_t rlog[$];
   int   m_ptr = 0;
   int   m_cyc = 0;
   int   m_last_id = 0;
   logic [DATA_W:0] m_last_res = '0;

   // Compare process: runs at every falling edge, checks outputs against the
   // model, then predicts what the next rising edge will accept.
   always begin
      @(negedge clk);
      if (!rst_n) begin
         check("rst_req_ready", 32'(req_ready), 32'h0);
         check("rst_add_a",     32'(add_a),     32'h0);
         check("rst_add_b",     32'(add_b),     32'h0);
         check("rst_add_cin",   32'(add_cin),   32'h0);
         check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
         check("rst_rsp_id",    32'(rsp_id),    32'h0);
         check("rst_rsp_sum",   32'(rsp_sum),   32'h0);
         check("rst_rsp_cout",  32'(rsp_cout),  32'h0);
         q.delete();
         m_ptr = 0;
         m_last_id = 0;
         m_last_res = '0;
      end else begin
         logic [NUM_REQ-1:0] elig, exp_ready, exp_valid;
         int gid, idx;
         elig = req_valid & req_en;
         gid = -1;
         for (int off = 0; off < NUM_REQ; off++) begin
            idx = (m_ptr + off) % NUM_REQ;
            if (gid < 0 && elig[idx]) gid = idx;
         end
         exp_ready = '0;
         if (gid >= 0) exp_ready[gid] = 1'b1;
         check("req_ready", 32'(req_ready), 32'(exp_ready));

         exp_valid = '0;
         if (q.size() > 0 && q[0].due == m_cyc) begin
            exp_t e;
            e = q.pop_front();
            exp_valid[e.id] = 1'b1;
            m_last_id  = e.id;
            m_last_res = e.res;
         end
         check("rsp_valid", 32'(rsp_valid), 32'(exp_valid));
         check("rsp_id",    32'(rsp_id),    32'(m_last_id));
         check("rsp_sum",   32'(rsp_sum),   32'(m_last_res[DATA_W-1:0]));
         check("rsp_cout",  32'(rsp_cout),  32'(m_last_res[DATA_W]));
         if (rsp_valid != '0) rlog.push_back('{int'(rsp_id), rsp_sum, rsp_cout});

         if (gid >= 0) begin
            exp_t n;
            n.due = m_cyc + 1 + PIPE_LAT;
            n.id  = gid;
            n.res = {1'b0, req_a[gid*DATA_W +: DATA_W]} + {1'b0, req_b[gid*DATA_W +: DATA_W]}
                    + (DATA_W+1)'(req_cin[gid]);
            q.push_back(n);
            m_ptr = (gid + 1) % NUM_REQ;
         end
      end
      m_cyc++;
   end

   task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b, input logic c);
      req_a[i*DATA_W +: DATA_W] = a;
      req_b[i*DATA_W +: DATA_W] = b;
      req_cin[i] = c;
   endtask

   task automatic cyc(input logic [3:0] v, input logic [3:0] en);
      req_valid = v;
      req_en    = en;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) cyc(4'b0000, 4'b1111);
   endtask

   task automatic check_log(input int i, input int id, input logic [7:0] sum, input logic cout);
      if (i < rlog.size()) begin
         check("log_id",   32'(rlog[i].id),   32'(id));
         check("log_sum",  32'(rlog[i].sum),  32'(sum));
         check("log_cout", 32'(rlog[i].cout), 32'(cout));
      end else begin
         check("log_missing", 32'(rlog.size()), 32'(i + 1));
      end
   endtask

   logic [7:0] fair_sum [4];

   initial begin
      fair_sum[0] = 8'h41; fair_sum[1] = 8'h52; fair_sum[2] = 8'h61; fair_sum[3] = 8'h72;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // Single op: FF + 01 -> 00 carry 1
      set_op(0, 8'hFF, 8'h01, 1'b0);
      cyc(4'b0001, 4'b1111);
      idle(5);
      check("single_count", 32'(rlog.size()), 32'd1);
      check_log(0, 0, 8'h00, 1'b1);
      rlog.delete();

      // Carry across the nibble boundary: 0F + 01 + 1 -> 11
      set_op(2, 8'h0F, 8'h01, 1'b1);
      cyc(4'b0100, 4'b1111);
      idle(5);
      check_log(0, 2, 8'h11, 1'b0);
      rlog.delete();

      // Back-to-back; requester 1 loses its enable while its op is in flight
      set_op(1, 8'h12, 8'h34, 1'b0);
      set_op(2, 8'hF0, 8'h0F, 1'b1);
      cyc(4'b0010, 4'b1111);
      cyc(4'b0100, 4'b1101);
      idle(5);
      check("b2b_count", 32'(rlog.size()), 32'd2);
      check_log(0, 1, 8'h46, 1'b0);
      check_log(1, 2, 8'h00, 1'b1);
      rlog.delete();

      // Reset pulse so the fairness run starts from pointer 0
      rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Fairness: all four valid for 8 cycles
      for (int i = 0; i < 4; i++) set_op(i, 8'(8'h10 * i + 8'h08), 8'h39, 1'(i & 1));
      for (int k = 0; k < 8; k++) cyc(4'b1111, 4'b1111);
      idle(5);
      check("fair_count", 32'(rlog.size()), 32'd8);
      for (int k = 0; k < 8; k++) check_log(k, k % 4, fair_sum[k % 4], 1'b0);
      rlog.delete();

      // Mask + bubble: only 1 and 3 enabled, gap cycle in the middle
      set_op(0, 8'hEE, 8'hEE, 1'b1);
      set_op(2, 8'hDD, 8'hDD, 1'b1);
      set_op(1, 8'h7C, 8'h15, 1'b0);
      set_op(3, 8'hA9, 8'h58, 1'b1);
      cyc(4'b1111, 4'b1010);
      cyc(4'b1111, 4'b1010);
      set_op(1, 8'h3E, 8'h4D, 1'b1);
      set_op(3, 8'hC4, 8'h2B, 1'b0);
      cyc(4'b0000, 4'b1010);
      cyc(4'b1111, 4'b1010);
      cyc(4'b1111, 4'b1010);
      idle(5);
      check("mask_count", 32'(rlog.size()), 32'd4);
      check_log(0, 1, 8'h91, 1'b0);
      check_log(1, 3, 8'h02, 1'b1);
      check_log(2, 1, 8'h8C, 1'b0);
      check_log(3, 3, 8'hEF, 1'b0);
      rlog.delete();

      // Reset one cycle after two accepts: in-flight ops must vanish
      set_op(0, 8'h55, 8'hAA, 1'b1);
      set_op(1, 8'h11, 8'h22, 1'b0);
      cyc(4'b0001, 4'b1111);
      cyc(4'b0010, 4'b1111);
      req_valid = 4'b0000;
      rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      idle(6);
      check("rst_no_stale", 32'(rlog.size()), 32'd0);
      set_op(0, 8'h6B, 8'h27, 1'b0);
      req_valid = 4'b1111;
      req_en    = 4'b1111;
      #1;
      check("rst_ptr_zero", 32'(req_ready), 32'h1);
      cyc(4'b1111, 4'b1111);
      idle(5);
      check("post_rst_count", 32'(rlog.size()), 32'd1);
      check_log(0, 0, 8'h92, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
